hazard_scoreboard: RTL and testbench

Parametrised register scoreboard for the pipelined core's decode stage. It generalises fixed-latency load-use hazard detection to units of variable result latency (loads, multi-cycle ALU/MUL). It tracks a per-register countdown of cycles until each pending result is available, and from that raises decode stall, operand-forward hits and write-after-write stalls. It also supports a one-deep undo when the execute stage is flushed.

---
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Purpose : decode-stage register scoreboard for variable-latency results; raises
//           operand stall, bypass-forward hits and WAW stalls, with a one-deep undo on execute flush.
// Latency : stall_d/fwd1/fwd2/issue_ack are combinational from state and inputs; busy and counters update on the next edge.
// Backpressure: stall_d holds decode; issue_ack is low while stalled or flushing.
// Ports   : clk, rst_n (async active-low); rs1_d/rs2_d + rsN_used (decode sources);
//           issue_valid/issue_rd/issue_lat (issuing producer); flush_e (undo last issue);
//           stall_d, fwd1, fwd2, issue_ack, busy[NREGS].
// Option  : define HAZARD_SB_FWD_EN to enable the bypass (threshold 1, fwd outputs live);
//           without it consumers wait for writeback (threshold 0, fwd outputs tied 0).
module hazard_scoreboard #(
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int MAXLAT = 4,
    parameter int LW     = $clog2(MAXLAT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rs1_d,
    input  logic [AW-1:0]     rs2_d,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    input  logic [LW-1:0]     issue_lat,
    input  logic              flush_e,
    output logic              stall_d,
    output logic              fwd1,
    output logic              fwd2,
    output logic              issue_ack,
    output logic [NREGS-1:0]  busy
);

`ifdef HAZARD_SB_FWD_EN
    localparam logic [LW-1:0] THR = LW'(1);
`else
    localparam logic [LW-1:0] THR = LW'(0);
`endif

    // Register 0 has no counter: it is never busy.
    logic [LW-1:0] cnt_q [1:NREGS-1];
    logic [LW-1:0] cnt_d [1:NREGS-1];
    logic          last_v_q,   last_v_d;
    logic [AW-1:0] last_rd_q,  last_rd_d;
    logic [LW-1:0] last_cnt_q, last_cnt_d;

    logic [LW-1:0] c1, c2, crd, lat_eff;
    logic          rd_ok, haz1, haz2, waw;

    function automatic logic [LW-1:0] sat_dec(input logic [LW-1:0] v);
        return (v == '0) ? '0 : v - LW'(1);
    endfunction

    // Counter lookups; addresses of 0 or beyond NREGS read as idle.
    always_comb begin
        c1    = '0;
        c2    = '0;
        crd   = '0;
        rd_ok = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (rs1_d == AW'(r))    c1 = cnt_q[r];
            if (rs2_d == AW'(r))    c2 = cnt_q[r];
            if (issue_rd == AW'(r)) begin
                crd   = cnt_q[r];
                rd_ok = 1'b1;
            end
        end
    end

    always_comb begin
        // Illegal latencies are pulled to the worst case so the scoreboard stays conservative.
        lat_eff = (issue_lat == '0 || issue_lat > LW'(MAXLAT)) ? LW'(MAXLAT) : issue_lat;
        haz1    = rs1_used && (rs1_d != '0) && (c1 > THR);
        haz2    = rs2_used && (rs2_d != '0) && (c2 > THR);
        // A younger write must not land before an older one to the same register.
        waw     = issue_valid && (issue_rd != '0) && (crd > lat_eff);
        stall_d   = haz1 || haz2 || waw;
        issue_ack = issue_valid && !stall_d && !flush_e;
`ifdef HAZARD_SB_FWD_EN
        fwd1 = rs1_used && (rs1_d != '0) && (c1 == LW'(1));
        fwd2 = rs2_used && (rs2_d != '0) && (c2 == LW'(1));
`else
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`endif
    end

    always_comb begin
        for (int r = 1; r < NREGS; r++) begin
            cnt_d[r] = sat_dec(cnt_q[r]);
            // Flush blocks issue_ack, so the two overrides never collide.
            if (flush_e && last_v_q && (last_rd_q == AW'(r)))
                cnt_d[r] = sat_dec(last_cnt_q);
            else if (issue_ack && (issue_rd == AW'(r)))
                cnt_d[r] = lat_eff;
        end
        // Shadow holds what the overwritten counter would have read next cycle.
        last_v_d   = issue_ack && rd_ok;
        last_rd_d  = last_v_d ? issue_rd     : last_rd_q;
        last_cnt_d = last_v_d ? sat_dec(crd) : last_cnt_q;
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREGS; r++) busy[r] = (cnt_q[r] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NREGS; r++) cnt_q[r] <= '0;
            last_v_q   <= 1'b0;
            last_rd_q  <= '0;
            last_cnt_q <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
            last_v_q   <= last_v_d;
            last_rd_q  <= last_rd_d;
            last_cnt_q <= last_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose : directed bench for hazard_scoreboard; driver queues expected outputs per cycle,
//           a negedge monitor pops and compares them.
// Latency : one expected record per driven cycle, checked mid-cycle.
// Backpressure: none; driver never waits on the DUT.
module tb_hazard_scoreboard;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int LW    = 3;
`ifdef HAZARD_SB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    rs1_d, rs2_d, issue_rd;
    logic             rs1_used, rs2_used, issue_valid, flush_e;
    logic [LW-1:0]    issue_lat;
    logic             stall_d, fwd1, fwd2, issue_ack;
    logic [NREGS-1:0] busy;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_lat(issue_lat),
        .flush_e(flush_e),
        .stall_d(stall_d), .fwd1(fwd1), .fwd2(fwd2), .issue_ack(issue_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && issue_valid)
            assert (issue_lat >= 1 && issue_lat <= 4) else $error("illegal issue_lat %0d", issue_lat);

    string            nm_q[$];
    logic [35:0]      exp_q[$];
    int               checks = 0;
    int               passes = 0;

    // Monitor: {stall_d, fwd1, fwd2, issue_ack, busy}
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            string       nm;
            logic [35:0] ex, act;
            nm  = nm_q.pop_front();
            ex  = exp_q.pop_front();
            act = {stall_d, fwd1, fwd2, issue_ack, busy};
            checks++;
            if (act === ex) passes++;
            else $display("FAIL %s: got stall=%b fwd1=%b fwd2=%b ack=%b busy=%h, want stall=%b fwd1=%b fwd2=%b ack=%b busy=%h",
                          nm, act[35], act[34], act[33], act[32], act[31:0],
                          ex[35], ex[34], ex[33], ex[32], ex[31:0]);
        end
    end

    function automatic logic [31:0] bit_of(input int r);
        logic [31:0] b;
        b = '0;
        b[r] = 1'b1;
        return b;
    endfunction

    task automatic cyc(input string nm,
                       input logic [AW-1:0] r1, input logic u1,
                       input logic [AW-1:0] r2, input logic u2,
                       input logic iv, input logic [AW-1:0] rd, input logic [LW-1:0] lat,
                       input logic fl,
                       input logic e_stall, input logic e_f1, input logic e_f2,
                       input logic e_ack, input logic [31:0] e_busy);
        rs1_d = r1; rs1_used = u1; rs2_d = r2; rs2_used = u2;
        issue_valid = iv; issue_rd = rd; issue_lat = lat; flush_e = fl;
        nm_q.push_back(nm);
        exp_q.push_back({e_stall, e_f1, e_f2, e_ack, e_busy});
        @(posedge clk); #1;
    endtask

    task automatic idle(input string nm, input logic [31:0] e_busy);
        cyc(nm, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, e_busy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rs1_d = '0; rs2_d = '0; rs1_used = 0; rs2_used = 0;
        issue_valid = 0; issue_rd = '0; issue_lat = 3'd1; flush_e = 0;
        @(posedge clk); #1;

        // In reset: no stall, ack follows issue_valid, nothing busy
        cyc("reset", 5, 1, 0, 0, 1, 5, 4, 0, 0, 0, 0, 1, 32'h0);
        rst_n = 1'b1;

        // Reset mid-flight
        cyc("rmf_issue", 0, 0, 0, 0, 1, 5, 4, 0, 0, 0, 0, 1, 32'h0);
        idle("rmf_busy", bit_of(5));
        rst_n = 1'b0;
        cyc("rmf_in_reset", 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        rst_n = 1'b1;
        cyc("rmf_after", 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);

        // Load-use: rd=3 lat=2
        cyc("lu_issue", 0, 0, 0, 0, 1, 3, 2, 0, 0, 0, 0, 1, 32'h0);
        cyc("lu_c1", 3, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, bit_of(3));
        cyc("lu_c2", 3, 1, 3, 1, 0, 0, 1, 0, !FWD, FWD, FWD, 0, bit_of(3));
        cyc("lu_c3", 3, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);

        // WAW: rd=7 lat=4 then rd=7 lat=1
        cyc("waw_issue1", 0, 0, 0, 0, 1, 7, 4, 0, 0, 0, 0, 1, 32'h0);
        cyc("waw_cnt4", 0, 0, 0, 0, 1, 7, 1, 0, 1, 0, 0, 0, bit_of(7));
        cyc("waw_cnt3", 0, 0, 0, 0, 1, 7, 1, 0, 1, 0, 0, 0, bit_of(7));
        cyc("waw_cnt2", 0, 0, 0, 0, 1, 7, 1, 0, 1, 0, 0, 0, bit_of(7));
        cyc("waw_cnt1_ack", 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 1, bit_of(7));
        cyc("waw_rs2", 0, 0, 7, 1, 0, 0, 1, 0, !FWD, 0, FWD, 0, bit_of(7));
        idle("waw_done", 32'h0);

        // Flush restore: rd=9 lat=4, then at cnt=2 rd=9 lat=3, flush next cycle
        cyc("fr_issue1", 0, 0, 0, 0, 1, 9, 4, 0, 0, 0, 0, 1, 32'h0);
        idle("fr_cnt4", bit_of(9));
        idle("fr_cnt3", bit_of(9));
        cyc("fr_issue2", 0, 0, 0, 0, 1, 9, 3, 0, 0, 0, 0, 1, bit_of(9));
        cyc("fr_flush", 9, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, bit_of(9));
        cyc("fr_restored", 9, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);

        // x0 writes ignored; flush after an rd=0 issue must not undo the older rd=10 issue
        cyc("x0_pre", 0, 0, 0, 0, 1, 10, 4, 0, 0, 0, 0, 1, 32'h0);
        cyc("x0_issue", 0, 1, 0, 0, 1, 0, 4, 0, 0, 0, 0, 1, bit_of(10));
        cyc("x0_flush", 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, bit_of(10));
        idle("x0_cnt2", bit_of(10));
        idle("x0_cnt1", bit_of(10));
        idle("x0_done", 32'h0);

        // Flush and issue together: issue not acknowledged
        cyc("fi_both", 0, 0, 0, 0, 1, 4, 3, 1, 0, 0, 0, 0, 32'h0);
        idle("fi_after", 32'h0);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
